// File: rtl/ling_adder_pipe_if.sv
// Operand/result handshake bundle for the pipelined Ling adder/subtractor.
// slave is the adder side, master is the operand-issue / result-consumer side.
interface ling_adder_pipe_if #(
    parameter int WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/ling_adder_pipe.sv
// Pipelined Ling adder/subtractor: each of STAGES slices resolves one WIDTH/STAGES-bit
// chunk; resolved sum bits and unresolved p/g/t travel with the beat.
module ling_adder_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ling_adder_pipe_if.slave  bus
);
    localparam int CW = WIDTH / STAGES;
    localparam int NG = CW / 4;

    // Ling pseudo-carries of one 4-bit group; c is the true carry into the group's bit 0.
    function automatic logic [3:0] ling_group(input logic [3:0] g, input logic [2:0] t, input logic c);
        logic [3:0] h;
        h[0] = g[0] | c;
        h[1] = g[1] | g[0] | (t[0] & c);
        h[2] = g[2] | g[1] | (t[1] & g[0]) | (t[1] & t[0] & c);
        h[3] = g[3] | g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0]) | (t[2] & t[1] & t[0] & c);
        return h;
    endfunction

    // One chunk: returns {carry_out, sum}.
    function automatic logic [CW:0] ling_chunk(input logic [CW-1:0] p, input logic [CW-1:0] g,
                                               input logic [CW-1:0] t, input logic ci);
        logic [CW-1:0] h;
        logic [CW-1:0] sum;
        logic          cg;
        h   = {CW{1'b0}};
        sum = {CW{1'b0}};
        cg  = ci;
        for (int q = 0; q < NG; q++) begin
            h[4*q +: 4] = ling_group(g[4*q +: 4], t[4*q +: 3], cg);
            cg          = t[4*q+3] & h[4*q+3];
        end
        sum[0] = p[0] ^ ci;
        for (int i = 1; i < CW; i++) begin
            sum[i] = p[i] ^ (t[i-1] & h[i-1]);
        end
        return {t[CW-1] & h[CW-1], sum};
    endfunction

    logic             advance_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic [WIDTH-1:0] b_e_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] t_s;
    logic             last_v_s;
    logic [WIDTH-1:0] last_x_s;
    logic             last_co_s;
    logic             last_pmsb_s;

    // The whole pipe moves in lockstep; bubbles are kept, not squeezed out.
    assign advance_s     = ~out_valid_r | bus.out_ready;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.s         = s_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

    // Front end: operand inversion for subtract, then bitwise p/g/t.
    always_comb begin
        b_e_s = bus.b;
        if (bus.sub) begin
            b_e_s = ~bus.b;
        end else begin
            b_e_s = bus.b;
        end
        p_s = bus.a ^ b_e_s;
        g_s = bus.a & b_e_s;
        t_s = bus.a | b_e_s;
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // x_r: bits below k*CW already hold sum, the rest still hold p.
        // g_r/t_r keep only the unresolved upper bits, chunk k at the bottom.
        localparam int UW = WIDTH - k * CW;

        logic             v_r;
        logic [WIDTH-1:0] x_r;
        logic [UW-1:0]    g_r;
        logic [UW-1:0]    t_r;
        logic             c_r;
        logic             v_in_s;
        logic [WIDTH-1:0] x_in_s;
        logic [UW-1:0]    g_in_s;
        logic [UW-1:0]    t_in_s;
        logic             c_in_s;
        logic [CW:0]      res_s;
        logic [CW-1:0]    sum_s;
        logic             co_s;
        logic [WIDTH-1:0] x_nxt_s;

        if (k == 0) begin : g_src
            assign v_in_s = bus.in_valid;
            assign x_in_s = p_s;
            assign g_in_s = g_s;
            assign t_in_s = t_s;
            assign c_in_s = bus.cin;
        end else begin : g_src
            assign v_in_s = stg[k-1].v_r;
            assign x_in_s = stg[k-1].x_nxt_s;
            assign g_in_s = stg[k-1].g_r[UW+CW-1:CW];
            assign t_in_s = stg[k-1].t_r[UW+CW-1:CW];
            assign c_in_s = stg[k-1].co_s;
        end

        assign res_s = ling_chunk(x_r[k*CW +: CW], g_r[CW-1:0], t_r[CW-1:0], c_r);
        assign sum_s = res_s[CW-1:0];
        assign co_s  = res_s[CW];

        // Splice the freshly resolved chunk over its p bits.
        always_comb begin
            x_nxt_s              = x_r;
            x_nxt_s[k*CW +: CW]  = sum_s;
        end

        // Slice register: loads only on a global advance.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                x_r <= {WIDTH{1'b0}};
                g_r <= {UW{1'b0}};
                t_r <= {UW{1'b0}};
                c_r <= 1'b0;
            end else if (advance_s) begin
                v_r <= v_in_s;
                x_r <= x_in_s;
                g_r <= g_in_s;
                t_r <= t_in_s;
                c_r <= c_in_s;
            end
        end
    end

    assign last_v_s    = stg[STAGES-1].v_r;
    assign last_x_s    = stg[STAGES-1].x_nxt_s;
    assign last_co_s   = stg[STAGES-1].co_s;
    assign last_pmsb_s = stg[STAGES-1].x_r[WIDTH-1];

    // Result register; carry into the MSB is recovered as s_msb ^ p_msb.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            s_r         <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= last_v_s;
            if (last_v_s) begin
                s_r    <= last_x_s;
                cout_r <= last_co_s;
                ovf_r  <= last_co_s ^ (last_x_s[WIDTH-1] ^ last_pmsb_s);
                zero_r <= ~|last_x_s;
            end
        end
    end
endmodule

// File: doc/ling_adder_pipe.md
# ling_adder_pipe

Parametrised, pipelined Ling adder/subtractor with valid/ready handshakes on input and output. It generalises the fixed 64-bit combinational Ling adder to any WIDTH that is a multiple of 4, splits the carry chain over STAGES register slices, and adds a subtract mode, signed-overflow and zero flags, and backpressure. It sits between operand-issue logic and the result bus in the datapath.

## Interface
- WIDTH, 64, operand/result width; multiple of 4·STAGES
- STAGES, 4, pipeline depth (1..8); each stage resolves CW = WIDTH/STAGES bits
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- sub  input  1  0: s = a + b + cin; 1: s = a + ~b + cin
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum
- cout  output  1  carry-out of bit WIDTH-1
- ovf  output  1  signed overflow
- zero  output  1  s == 0

## Operation
- Front end: b_e = sub ? ~b : b; g = a&b_e, t = a|b_e, p = a^b_e; c0 = cin. No implicit +1 in subtract; caller drives cin=1 for a−b.
- Stage k (0..STAGES-1) resolves chunk k, bits [k·CW +: CW], from registered p/g/t of that chunk and the registered incoming carry (stage 0 uses c0).
- Within a chunk: 4-bit Ling groups. In each group, h_j = g_j | g_(j-1) | … with t terms; the group's MSB pseudo-carry is chained to the next group via t[msb]&h[msb]. Sum bit 0 of the chunk is p ^ cin_chunk. Other bits are s_i = p_i ^ (t_(i-1) & h_(i-1)). Chunk carry-out is t_msb & h_msb.
- Unresolved upper-chunk p/g/t and resolved lower sum bits travel with the beat in skew registers. Stage k outputs its chunk's sum plus its carry-out to stage k+1.
- Final stage registers s, cout = carry-out of chunk STAGES-1, ovf = cout ^ c_(WIDTH-1) (carry into MSB = t_(W-2)&h_(W-2)), zero = ~|s.
- Pipeline valid bit per stage. Global advance = ~out_valid | out_ready. All stages shift only when advance=1. Bubbles are not collapsed.
- in_ready = advance (combinational from out_valid, out_ready). A beat is accepted when in_valid & in_ready.
- Stall (advance=0): every stage register, s, cout, ovf, zero and out_valid hold. Output is stable while out_valid & ~out_ready.
- Reset (rst_n=0 at edge): all stage valid bits, out_valid, s, cout, ovf and zero go to 0. Data in flight is discarded, including a beat mid-pipeline. in_ready reads 1 in the first cycle after reset.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES, given no stall.
- Throughput: 1 beat/cycle when out_ready=1 continuously.
- Stall adds exactly the stalled cycle count to latency. No beat is dropped or duplicated.
- Simultaneous out_valid & out_ready & in_valid: output pops, pipeline shifts and the new beat enters in the same edge.
- Critical path per stage: one CW-bit Ling chunk plus the carry mux. No combinational path from a/b to s.
- out_ready → in_ready is the only combinational input→output path.

## Test plan
- WIDTH=64, STAGES=4. Drive a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 → after 4 edges s=0, cout=1, ovf=0, zero=1. This covers a full carry ripple across all chunks.
- Subtract: a=5, b=7, sub=1, cin=1 → s=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0, zero=0. Then a=7, b=5 → s=2, cout=1.
- Overflow: a=7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → s=8000_0000_0000_0000, ovf=1, cout=0. Then a=8000_0000_0000_0000, b=8000_0000_0000_0000 → s=0, cout=1, ovf=1, zero=1.
- Backpressure: stream 6 beats while holding out_ready=0.
  - Required: in_ready drops to 0 once out_valid=1, and s holds.
  - After out_ready is released, all beats exit in order with correct sums. No loss, no duplication.
- Reset mid-stream: assert rst_n=0 for one edge with 3 beats in flight → next cycle out_valid=0, s=0, in_ready=1. Those beats never appear at the output.
- Random regression with WIDTH∈{16,64,128}, STAGES∈{1,2,4}, random in_valid/out_ready/sub/cin.
  - Required: s, cout and ovf match a scoreboard computing the (WIDTH+1)-bit sum a + (sub?~b:b) + cin, with ovf taken from the sign bits.
  - Result order matches issue order.
